// File: rtl/core_pkg.sv
// Shared core definitions for the ID/EX slice.
//   XLEN / REG_W : datapath and register-address widths
//   OP_*         : major opcodes used by decode and the EX-side logic
//   ALU_*        : ALU operation-select encodings
//   ctrl_t       : packed control bundle carried from ID into EX
package core_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX instruction bus.
//   id_* : decoded instruction presented by ID (driven by the decoder side)
//   ex_* : registered EX-stage copies (driven by the ID/EX register)
// Modports:
//   master : decode side, drives id_*, observes ex_*
//   slave  : the ID/EX register, consumes id_*, drives ex_*
// There is no valid/ready handshake on this bus: id_valid qualifies the ID
// fields, and flow control is done with ex_flush / mem_stall / if_id_hold.
interface id_ex_stage_if #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int REG_W = core_pkg::REG_W
);

  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic [6:0]       id_op_code;
  logic [3:0]       id_alu_ctrl;
  logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic             ex_rs1_used, ex_rs2_used;
  logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0]       ex_op_code;
  logic [3:0]       ex_alu_ctrl;
  logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_op_code, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_used, ex_rs2_used,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_op_code, ex_alu_ctrl,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_op_code, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_used, ex_rs2_used,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_op_code, ex_alu_ctrl,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   ex_valid, ex_mem_read, ex_rd      : instruction currently in EX
//   id_valid, id_rs1/2, id_rs1/2_used : instruction currently in ID
//   hz                                : ID reads the register a load in EX
//                                       is about to produce
module hazard_detect #(
  parameter int REG_W = core_pkg::REG_W
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             hz
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and stall/flush
// performance counters.
//   clk, rst       : core clock, synchronous active-high reset
//   bus (slave)    : id_* in, registered ex_* out
//   ex_flush       : taken branch/jump in EX, squash what enters EX
//   mem_stall      : downstream not ready, freeze the EX register
//   load_use_stall : bubble inserted this cycle (combinational)
//   if_id_hold     : PC and IF/ID must not advance (combinational)
//   stall_count    : saturating count of load-use bubbles
//   flush_count    : saturating count of flush cycles
// Update priority each edge: rst > ex_flush > mem_stall > hazard > capture.
module id_ex_stage #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int REG_W = core_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic             load_use_stall,
  output logic             if_id_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  import core_pkg::*;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [6:0]       op_code;
    ctrl_t            ctrl;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t ex_q, ex_d, id_rec;
  logic   hz;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .hz          (hz)
  );

  // A flush squashes IF/ID upstream, so it suppresses both stall indications.
  assign load_use_stall = hz && !ex_flush && !mem_stall;
  assign if_id_hold     = !ex_flush && (mem_stall || hz);

  // ID record as captured; control bits only survive for a real instruction
  // so an invalid slot can never write the register file or memory.
  always_comb begin
    id_rec          = '0;
    id_rec.valid    = bus.id_valid;
    id_rec.pc       = bus.id_pc;
    id_rec.rs1      = bus.id_rs1;
    id_rec.rs2      = bus.id_rs2;
    id_rec.rs1_used = bus.id_rs1_used;
    id_rec.rs2_used = bus.id_rs2_used;
    id_rec.rd       = bus.id_rd;
    id_rec.rs1_data = bus.id_rs1_data;
    id_rec.rs2_data = bus.id_rs2_data;
    id_rec.imm      = bus.id_imm;
    id_rec.op_code  = bus.id_op_code;
    if (bus.id_valid) begin
      id_rec.ctrl.reg_write  = bus.id_reg_write;
      id_rec.ctrl.mem_read   = bus.id_mem_read;
      id_rec.ctrl.mem_write  = bus.id_mem_write;
      id_rec.ctrl.mem_to_reg = bus.id_mem_to_reg;
      id_rec.ctrl.alu_src    = bus.id_alu_src;
      id_rec.ctrl.alu_ctrl   = bus.id_alu_ctrl;
    end
  end

  // Bubble is the all-zero record (op_code 0 matches no real opcode).
  always_comb begin
    ex_d = ex_q;
    if (ex_flush)       ex_d = '0;
    else if (mem_stall) ex_d = ex_q;
    else if (hz)        ex_d = '0;
    else                ex_d = id_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (load_use_stall && stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      if (ex_flush && flush_count != CNT_MAX)       flush_count <= flush_count + CNT_ONE;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rs1_used   = ex_q.rs1_used;
  assign bus.ex_rs2_used   = ex_q.rs2_used;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_rs1_data   = ex_q.rs1_data;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_op_code    = ex_q.op_code;
  assign bus.ex_alu_ctrl   = ex_q.ctrl.alu_ctrl;
  assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
  assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
  assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
  assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign bus.ex_alu_src    = ex_q.ctrl.alu_src;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [6:0]  op;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        as;
    logic [3:0]  alu;
  } rec_t;

  localparam int RW = $bits(rec_t);
  localparam int K_CAP = 0;
  localparam int K_BUB = 1;
  localparam int K_HOLD = 2;

  typedef struct {
    rec_t id;
    logic flush;
    logic stall;
    logic exp_lus;
    logic exp_hold;
    int   kind;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage_if bus2 ();

  logic        ex_flush, mem_stall, lus, hold;
  logic [31:0] stall_count, flush_count;
  logic        ex_flush2, mem_stall2, lus2, hold2;
  logic [1:0]  sc2, fc2;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ex_flush(ex_flush), .mem_stall(mem_stall),
    .load_use_stall(lus), .if_id_hold(hold), .stall_count(stall_count), .flush_count(flush_count)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .ex_flush(ex_flush2), .mem_stall(mem_stall2),
    .load_use_stall(lus2), .if_id_hold(hold2), .stall_count(sc2), .flush_count(fc2)
  );

  logic [RW-1:0] ex_now;
  assign ex_now = {bus.ex_valid, bus.ex_pc, bus.ex_rs1, bus.ex_rs2, bus.ex_rs1_used,
                   bus.ex_rs2_used, bus.ex_rd, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                   bus.ex_op_code, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                   bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_ctrl};

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic rec_t instr(input logic [31:0] pc, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    rec_t r;
    r = '0;
    r.valid = 1'b1;
    r.pc = pc;
    r.op = op;
    r.rd = rd;
    r.rs1 = rs1;
    r.rs2 = rs2;
    r.rs1_data = $urandom;
    r.rs2_data = $urandom;
    r.imm = $urandom_range(0, 4095);
    case (op)
      OP_LOAD:  begin r.rs1_used = 1; r.rw = 1; r.mr = 1; r.m2r = 1; r.as = 1; r.alu = ALU_ADD; end
      OP_STORE: begin r.rs1_used = 1; r.rs2_used = 1; r.mw = 1; r.as = 1; r.alu = ALU_ADD; end
      OP_OP:    begin r.rs1_used = 1; r.rs2_used = 1; r.rw = 1; r.alu = ALU_ADD; end
      OP_OPIMM: begin r.rs1_used = 1; r.rw = 1; r.as = 1; r.alu = ALU_OR; end
      OP_LUI:   begin r.rw = 1; r.as = 1; r.alu = ALU_PASSB; end
      default:  r.alu = ALU_ADD;
    endcase
    return r;
  endfunction

  // What EX must hold after capturing r: no control bits for an empty slot.
  function automatic rec_t cap_of(input rec_t r);
    rec_t c;
    c = r;
    if (!r.valid) begin
      c.rw = 0; c.mr = 0; c.mw = 0; c.m2r = 0; c.as = 0; c.alu = '0;
    end
    return c;
  endfunction

  task automatic drive(input rec_t r, input logic fl, input logic st);
    bus.id_valid = r.valid;       bus.id_pc = r.pc;
    bus.id_rs1 = r.rs1;           bus.id_rs2 = r.rs2;
    bus.id_rs1_used = r.rs1_used; bus.id_rs2_used = r.rs2_used;
    bus.id_rd = r.rd;             bus.id_rs1_data = r.rs1_data;
    bus.id_rs2_data = r.rs2_data; bus.id_imm = r.imm;
    bus.id_op_code = r.op;        bus.id_alu_ctrl = r.alu;
    bus.id_reg_write = r.rw;      bus.id_mem_read = r.mr;
    bus.id_mem_write = r.mw;      bus.id_mem_to_reg = r.m2r;
    bus.id_alu_src = r.as;
    ex_flush = fl;
    mem_stall = st;
  endtask

  task automatic drive2(input rec_t r, input logic fl, input logic st);
    bus2.id_valid = r.valid;       bus2.id_pc = r.pc;
    bus2.id_rs1 = r.rs1;           bus2.id_rs2 = r.rs2;
    bus2.id_rs1_used = r.rs1_used; bus2.id_rs2_used = r.rs2_used;
    bus2.id_rd = r.rd;             bus2.id_rs1_data = r.rs1_data;
    bus2.id_rs2_data = r.rs2_data; bus2.id_imm = r.imm;
    bus2.id_op_code = r.op;        bus2.id_alu_ctrl = r.alu;
    bus2.id_reg_write = r.rw;      bus2.id_mem_read = r.mr;
    bus2.id_mem_write = r.mw;      bus2.id_mem_to_reg = r.m2r;
    bus2.id_alu_src = r.as;
    ex_flush2 = fl;
    mem_stall2 = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];

  task automatic add_vec(input rec_t id, input logic fl, input logic st,
                         input logic el, input logic eh, input int kind);
    vec_t v;
    v.id = id; v.flush = fl; v.stall = st; v.exp_lus = el; v.exp_hold = eh; v.kind = kind;
    vt.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    rec_t i_lw5, i_add6, i_lw0, i_add9, i_lw5b, i_lui5, i_lw5c, i_lw7, i_add8, i_sw;
    rec_t i_inv, i_add3, i_lw100, i_a, i_b, i_c, i_lw4, i_add1, idle;
    rec_t e, last_exp;
    int   n;

    idle = '0;
    rst = 1'b1;
    drive(idle, 1'b0, 1'b0);
    drive2(idle, 1'b0, 1'b0);
    step();
    chk("reset_ex", ex_now, '0);
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_flush_count", flush_count, 32'd0);
    chk("reset_lus", lus, 1'b0);
    chk("reset_hold", hold, 1'b0);
    rst = 1'b0;

    i_lw5   = instr(32'h000, OP_LOAD,  5'd5,  5'd1, 5'd0);
    i_add6  = instr(32'h004, OP_OP,    5'd6,  5'd5, 5'd7);
    i_lw0   = instr(32'h008, OP_LOAD,  5'd0,  5'd2, 5'd0);
    i_add9  = instr(32'h00c, OP_OP,    5'd9,  5'd0, 5'd0);
    i_lw5b  = instr(32'h010, OP_LOAD,  5'd5,  5'd3, 5'd0);
    i_lui5  = instr(32'h014, OP_LUI,   5'd5,  5'd5, 5'd0);
    i_lw5c  = instr(32'h018, OP_LOAD,  5'd5,  5'd4, 5'd0);
    i_lw7   = instr(32'h01c, OP_LOAD,  5'd7,  5'd5, 5'd0);
    i_add8  = instr(32'h020, OP_OP,    5'd8,  5'd1, 5'd7);
    i_sw    = instr(32'h024, OP_STORE, 5'd0,  5'd2, 5'd7);
    i_inv   = instr(32'h028, OP_OP,    5'd10, 5'd7, 5'd7);
    i_inv.valid = 1'b0;
    i_add3  = instr(32'h02c, OP_OP,    5'd3,  5'd1, 5'd2);
    i_lw100 = instr(32'h100, OP_LOAD,  5'd5,  5'd1, 5'd0);
    i_a     = instr(32'h104, OP_OP,    5'd6,  5'd5, 5'd7);
    i_b     = instr(32'h108, OP_OPIMM, 5'd11, 5'd5, 5'd0);
    i_c     = instr(32'h10c, OP_STORE, 5'd0,  5'd5, 5'd5);
    i_lw4   = instr(32'h200, OP_LOAD,  5'd4,  5'd1, 5'd0);
    i_add1  = instr(32'h204, OP_OP,    5'd1,  5'd4, 5'd4);

    //       id       fl st lus hold kind
    add_vec(i_lw5,   0, 0, 0, 0, K_CAP);   // EX empty, load enters
    add_vec(i_add6,  0, 0, 1, 1, K_BUB);   // load-use on rs1
    add_vec(i_add6,  0, 0, 0, 0, K_CAP);   // dependent enters one cycle later
    add_vec(i_lw0,   0, 0, 0, 0, K_CAP);
    add_vec(i_add9,  0, 0, 0, 0, K_CAP);   // load to x0 never stalls
    add_vec(i_lw5b,  0, 0, 0, 0, K_CAP);
    add_vec(i_lui5,  0, 0, 0, 0, K_CAP);   // rs1 matches but is unused
    add_vec(i_lw5c,  0, 0, 0, 0, K_CAP);
    add_vec(i_lw7,   0, 0, 1, 1, K_BUB);   // load after load, dependent
    add_vec(i_lw7,   0, 0, 0, 0, K_CAP);   // bubble in EX cannot trigger
    add_vec(i_add8,  1, 0, 0, 0, K_BUB);   // flush beats load-use on rs2
    add_vec(i_sw,    0, 0, 0, 0, K_CAP);
    add_vec(i_inv,   0, 0, 0, 0, K_CAP);   // empty slot, control forced to 0
    add_vec(i_add3,  0, 0, 0, 0, K_CAP);
    add_vec(i_lw100, 0, 0, 0, 0, K_CAP);
    add_vec(i_a,     0, 1, 0, 1, K_HOLD);  // memory stall hides hazard
    add_vec(i_b,     0, 1, 0, 1, K_HOLD);
    add_vec(i_c,     0, 1, 0, 1, K_HOLD);
    add_vec(i_a,     0, 0, 1, 1, K_BUB);   // stall released, hazard resumes
    add_vec(i_a,     0, 0, 0, 0, K_CAP);
    add_vec(i_lw4,   0, 0, 0, 0, K_CAP);
    add_vec(i_add1,  1, 1, 0, 0, K_BUB);   // flush beats stall and hazard

    last_exp = '0;
    foreach (vt[i]) begin
      drive(vt[i].id, vt[i].flush, vt[i].stall);
      #1;
      chk($sformatf("vec%0d_lus", i), lus, vt[i].exp_lus);
      chk($sformatf("vec%0d_hold", i), hold, vt[i].exp_hold);
      case (vt[i].kind)
        K_CAP:   e = cap_of(vt[i].id);
        K_BUB:   e = '0;
        default: e = last_exp;
      endcase
      exp_q.push_back(e);
      last_exp = e;
      step();
      chk($sformatf("vec%0d_ex", i), ex_now, exp_q.pop_front());
      if (vt[i].kind == K_HOLD) chk($sformatf("vec%0d_ex_pc", i), bus.ex_pc, 32'h100);
    end
    chk("table_stall_count", stall_count, 32'd3);
    chk("table_flush_count", flush_count, 32'd2);

    // Reset asserted while a load-use hazard is pending.
    drive(i_lw5, 0, 0);
    step();
    drive(i_add6, 0, 0);
    #1;
    chk("pre_rst_lus", lus, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_ex", ex_now, '0);
    chk("rst_mid_stall_count", stall_count, 32'd0);
    chk("rst_mid_flush_count", flush_count, 32'd0);
    chk("rst_mid_lus", lus, 1'b0);
    chk("rst_mid_hold", hold, 1'b0);
    drive(i_add6, 1, 0);  // flush while in reset must not count
    step();
    chk("rst_flush_count", flush_count, 32'd0);
    chk("rst_flush_ex", ex_now, '0);
    rst = 1'b0;

    // Flush and hazard in the same cycle, counted from a clean reset.
    drive(i_lw5, 0, 0);
    step();
    chk("lw_capture_ex", ex_now, cap_of(i_lw5));
    drive(i_add6, 1, 0);
    #1;
    chk("flush_hz_lus", lus, 1'b0);
    chk("flush_hz_hold", hold, 1'b0);
    step();
    chk("flush_hz_ex", ex_now, '0);
    chk("flush_hz_flush_count", flush_count, 32'd1);
    chk("flush_hz_stall_count", stall_count, 32'd0);
    drive(idle, 0, 0);

    // Saturation on a narrow-counter instance.
    for (int k = 1; k <= 5; k++) begin
      drive2(i_lw5, 0, 0);
      step();
      drive2(i_add6, 0, 0);
      step();
      n = (k > 3) ? 3 : k;
      chk($sformatf("sat_stall_%0d", k), sc2, n[1:0]);
    end
    for (int k = 1; k <= 5; k++) begin
      drive2(idle, 1, 0);
      step();
      n = (k > 3) ? 3 : k;
      chk($sformatf("sat_flush_%0d", k), fc2, n[1:0]);
    end
    chk("sat_stall_after_flush", sc2, 2'd3);
    drive2(idle, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
